// File: rtl/jj_render_pkg.sv
// Shared encodings and default geometry for the playfield renderer.
// Imported by the renderer top and its raster counters.
package jj_render_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIELD  = 2'd1,
        SPRITE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_FIELD_W  = 120;
    localparam int DEF_FIELD_H  = 100;
    localparam int DEF_X_OFF    = 20;
    localparam int DEF_Y_OFF    = 10;
    localparam int DEF_SPRITE_W = 4;
    localparam int DEF_SPRITE_H = 6;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/playfield_renderer_if.sv
// Field-memory read port and pixel output bundle of the renderer.
// master = renderer side, slave = memory / VGA adapter side.
interface playfield_renderer_if #(
    parameter int ADDR_W   = 14,
    parameter int XW       = 8,
    parameter int YW       = 8,
    parameter int COLOUR_W = 3
);
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic                mem_data;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    modport master (
        output mem_addr, mem_rd, x, y, colour, plot,
        input  mem_data
    );

    modport slave (
        input  mem_addr, mem_rd, x, y, colour, plot,
        output mem_data
    );
endinterface

// File: rtl/playfield_renderer_raster.sv
// Column-major col/row counter with enable, clear and a last flag.
// Wraps to (0,0) after the last position.
module raster_counter
    import jj_render_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 3,
    parameter int CW     = cw(WIDTH),
    parameter int RW     = cw(HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);
    localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RMAX = RW'(HEIGHT - 1);

    assign last = (col == CMAX) && (row == RMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (row == RMAX) begin
                row <= '0;
                col <= (col == CMAX) ? '0 : col + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
        end
    end
endmodule

// File: rtl/playfield_renderer.sv
// Scans the 1-bit playfield through a 1-cycle-latency read port, then
// overlays a clipped rectangular sprite, one pixel per cycle.
module playfield_renderer
    import jj_render_pkg::*;
#(
    parameter int FIELD_W  = DEF_FIELD_W,
    parameter int FIELD_H  = DEF_FIELD_H,
    parameter int X_OFF    = DEF_X_OFF,
    parameter int Y_OFF    = DEF_Y_OFF,
    parameter int SPRITE_W = DEF_SPRITE_W,
    parameter int SPRITE_H = DEF_SPRITE_H,
    parameter int XW       = 8,
    parameter int YW       = 8,
    parameter int COLOUR_W = 3,
    parameter int DRAW_BG  = 1,
    parameter int ADDR_W   = $clog2(FIELD_W * FIELD_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [XW-1:0]       sprite_x,
    input  logic [YW-1:0]       sprite_y,
    input  logic [COLOUR_W-1:0] fg_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    input  logic [COLOUR_W-1:0] sprite_colour,
    playfield_renderer_if.master bus,
    output logic                busy,
    output logic                done
);
    localparam int FCW = cw(FIELD_W);
    localparam int FRW = cw(FIELD_H);
    localparam int SCW = cw(SPRITE_W);
    localparam int SRW = cw(SPRITE_H);
    localparam logic [XW:0] FW_L = (XW + 1)'(FIELD_W);
    localparam logic [YW:0] FH_L = (YW + 1)'(FIELD_H);
    localparam logic        BG_ON = (DRAW_BG != 0);

    state_t state_q, state_d;
    logic   fld_en, spr_en, clr, ld;
    logic   fld_last, spr_last, spr_end_q;

    logic [FCW-1:0] fcol;
    logic [FRW-1:0] frow;
    logic [SCW-1:0] si;
    logic [SRW-1:0] sj;

    logic [ADDR_W-1:0]   addr_q;
    logic [XW-1:0]       sx_q, px_x;
    logic [YW-1:0]       sy_q, px_y;
    logic [COLOUR_W-1:0] sc_q;
    logic                fv_q, sv_q, sin_q;

    logic [XW:0] sx_sum;
    logic [YW:0] sy_sum;
    logic        spr_in;

    raster_counter #(.WIDTH(FIELD_W), .HEIGHT(FIELD_H)) u_field (
        .clk(clk), .reset(reset), .en(fld_en), .clr(clr),
        .col(fcol), .row(frow), .last(fld_last)
    );

    raster_counter #(.WIDTH(SPRITE_W), .HEIGHT(SPRITE_H)) u_sprite (
        .clk(clk), .reset(reset), .en(spr_en), .clr(clr),
        .col(si), .row(sj), .last(spr_last)
    );

    // SPRITE holds one extra cycle so the last sprite pixel drains
    always_comb begin
        state_d = state_q;
        fld_en  = 1'b0;
        spr_en  = 1'b0;
        unique case (state_q)
            IDLE:   if (start) state_d = FIELD;
            FIELD: begin
                fld_en = 1'b1;
                if (fld_last) state_d = SPRITE;
            end
            SPRITE: begin
                if (spr_end_q) state_d = DONE;
                else           spr_en  = 1'b1;
            end
            DONE:   state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            fld_en  = 1'b0;
            spr_en  = 1'b0;
        end
    end

    assign ld  = (state_q == IDLE) && start && !abort;
    assign clr = (state_q == IDLE) || abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Widened sums so an off-field sprite never wraps back in bounds
    assign sx_sum = {1'b0, sx_q} + (XW + 1)'(si);
    assign sy_sum = {1'b0, sy_q} + (YW + 1)'(sj);
    assign spr_in = (sx_sum < FW_L) && (sy_sum < FH_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            spr_end_q <= 1'b0;
            sx_q      <= '0;
            sy_q      <= '0;
            sc_q      <= '0;
            px_x      <= '0;
            px_y      <= '0;
            fv_q      <= 1'b0;
            sv_q      <= 1'b0;
            sin_q     <= 1'b0;
        end else begin
            if (ld) begin
                sx_q <= sprite_x;
                sy_q <= sprite_y;
                sc_q <= sprite_colour;
            end
            if (clr)         addr_q <= '0;
            else if (fld_en) addr_q <= fld_last ? '0 : addr_q + 1'b1;
            spr_end_q <= spr_en && spr_last;
            fv_q      <= fld_en;
            sv_q      <= spr_en;
            sin_q     <= spr_in;
            if (fld_en) begin
                px_x <= XW'(X_OFF) + XW'(fcol);
                px_y <= YW'(Y_OFF) + YW'(frow);
            end else if (spr_en) begin
                px_x <= XW'(X_OFF) + sx_q + XW'(si);
                px_y <= YW'(Y_OFF) + sy_q + YW'(sj);
            end
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_rd   = (state_q == FIELD);
    assign bus.x        = px_x;
    assign bus.y        = px_y;
    assign bus.colour   = fv_q ? (bus.mem_data ? fg_colour : bg_colour)
                        : (sv_q ? sc_q : '0);
    assign bus.plot     = (fv_q && (bus.mem_data || BG_ON)) || (sv_q && sin_q);

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_playfield_renderer.sv
// Bench for playfield_renderer: 4x3 field, 2x2 sprite, DRAW_BG 0 and 1
// instances side by side against a per-cycle expectation model.
module tb_playfield_renderer;
    import jj_render_pkg::*;

    localparam int FW = 4;
    localparam int FH = 3;
    localparam int SW = 2;
    localparam int SH = 2;
    localparam int XO = 20;
    localparam int YO = 10;
    localparam int NC = 24;
    localparam int LAT = FW * FH + SW * SH + 2;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [7:0] sprite_x, sprite_y;
    logic [2:0] fg, bg, sc;
    logic       busy0, done0, busy1, done1;
    logic       fmem [0:15];

    int total = 0;
    int bad   = 0;

    playfield_renderer_if #(.ADDR_W(4), .XW(8), .YW(8), .COLOUR_W(3)) b0 ();
    playfield_renderer_if #(.ADDR_W(4), .XW(8), .YW(8), .COLOUR_W(3)) b1 ();

    playfield_renderer #(
        .FIELD_W(FW), .FIELD_H(FH), .X_OFF(XO), .Y_OFF(YO),
        .SPRITE_W(SW), .SPRITE_H(SH), .XW(8), .YW(8), .COLOUR_W(3),
        .DRAW_BG(0), .ADDR_W(4)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .fg_colour(fg), .bg_colour(bg), .sprite_colour(sc),
        .bus(b0), .busy(busy0), .done(done0)
    );

    playfield_renderer #(
        .FIELD_W(FW), .FIELD_H(FH), .X_OFF(XO), .Y_OFF(YO),
        .SPRITE_W(SW), .SPRITE_H(SH), .XW(8), .YW(8), .COLOUR_W(3),
        .DRAW_BG(1), .ADDR_W(4)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .fg_colour(fg), .bg_colour(bg), .sprite_colour(sc),
        .bus(b1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // 1-cycle latency field memory for each instance
    always @(posedge clk) begin
        b0.mem_data <= b0.mem_rd ? fmem[b0.mem_addr] : 1'b0;
        b1.mem_data <= b1.mem_rd ? fmem[b1.mem_addr] : 1'b0;
    end

    int e_plot [2][NC];
    int e_x    [2][NC];
    int e_y    [2][NC];
    int e_c    [2][NC];
    int e_busy [NC];
    int e_done [NC];
    int e_rd   [NC];
    int e_addr [NC];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic build_model(input int sx, input int sy, input int scol,
                               input int f, input int b, input int ab);
        for (int c = 0; c < NC; c++) begin
            e_busy[c] = (c >= 1 && c <= LAT) ? 1 : 0;
            e_done[c] = (c == LAT) ? 1 : 0;
            e_rd[c]   = (c >= 1 && c <= FW * FH) ? 1 : 0;
            e_addr[c] = c - 1;
            for (int d = 0; d < 2; d++) begin
                e_plot[d][c] = 0;
                e_x[d][c] = 0;
                e_y[d][c] = 0;
                e_c[d][c] = 0;
            end
        end
        for (int col = 0; col < FW; col++)
            for (int row = 0; row < FH; row++) begin
                int c;
                c = 2 + col * FH + row;
                for (int d = 0; d < 2; d++) begin
                    e_x[d][c] = XO + col;
                    e_y[d][c] = YO + row;
                    if (fmem[col * FH + row]) begin
                        e_plot[d][c] = 1;
                        e_c[d][c] = f;
                    end else begin
                        e_plot[d][c] = d;
                        e_c[d][c] = b;
                    end
                end
            end
        for (int i = 0; i < SW; i++)
            for (int j = 0; j < SH; j++) begin
                int c;
                c = FW * FH + 2 + i * SH + j;
                for (int d = 0; d < 2; d++) begin
                    e_x[d][c] = XO + sx + i;
                    e_y[d][c] = YO + sy + j;
                    e_c[d][c] = scol;
                    e_plot[d][c] = (sx + i < FW && sy + j < FH) ? 1 : 0;
                end
            end
        if (ab >= 0)
            for (int c = ab + 1; c < NC; c++) begin
                e_busy[c] = 0;
                e_done[c] = 0;
                e_rd[c] = 0;
                e_plot[0][c] = 0;
                e_plot[1][c] = 0;
            end
    endtask

    task automatic check_cycle(input int c, inout int p0, inout int p1);
        for (int d = 0; d < 2; d++) begin
            int pl, bs, dn, rd, ad, xx, yy, cc;
            pl = d ? b1.plot : b0.plot;
            bs = d ? busy1 : busy0;
            dn = d ? done1 : done0;
            rd = d ? b1.mem_rd : b0.mem_rd;
            ad = d ? b1.mem_addr : b0.mem_addr;
            xx = d ? b1.x : b0.x;
            yy = d ? b1.y : b0.y;
            cc = d ? b1.colour : b0.colour;
            chk($sformatf("d%0d_busy@%0d", d, c), bs, e_busy[c]);
            chk($sformatf("d%0d_done@%0d", d, c), dn, e_done[c]);
            chk($sformatf("d%0d_rd@%0d", d, c), rd, e_rd[c]);
            if (e_rd[c] != 0)
                chk($sformatf("d%0d_addr@%0d", d, c), ad, e_addr[c]);
            chk($sformatf("d%0d_plot@%0d", d, c), pl, e_plot[d][c]);
            if (e_plot[d][c] != 0) begin
                chk($sformatf("d%0d_x@%0d", d, c), xx, e_x[d][c]);
                chk($sformatf("d%0d_y@%0d", d, c), yy, e_y[d][c]);
                chk($sformatf("d%0d_col@%0d", d, c), cc, e_c[d][c]);
            end
            if (d == 0) p0 += pl;
            else        p1 += pl;
        end
    endtask

    task automatic run_frame(input int sx, input int sy, input int scol,
                             input int f, input int b, input int ab,
                             input int glitch, output int p0, output int p1);
        int ncyc;
        ncyc = (ab >= 0) ? ab + 2 : 21;
        p0 = 0;
        p1 = 0;
        fg = 3'(f);
        bg = 3'(b);
        build_model(sx, sy, scol, f, b, ab);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check_cycle(c, p0, p1);
            start = (c == 0) || (glitch != 0 && (c == 5 || c == 17 || c == 18));
            abort = (c == ab);
            sprite_x = (c == 0) ? 8'(sx) : 8'(sx + 1);
            sprite_y = (c == 0) ? 8'(sy) : 8'(sy + 1);
            sc = (c == 0) ? 3'(scol) : ~3'(scol);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        int sx, sy, scol, f, b, ab, glitch, ep0, ep1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int p0, p1;
        logic [11:0] pat;

        tbl[0] = '{1, 1, 5, 3, 6, -1, 0, 10, 16};
        tbl[1] = '{3, 2, 2, 7, 1, -1, 0, 7, 13};
        tbl[2] = '{1, 1, 4, 1, 2, -1, 1, 10, 16};
        tbl[3] = '{1, 1, 5, 3, 6, 7, 0, 3, 6};
        tbl[4] = '{2, 0, 1, 4, 3, -1, 0, 10, 16};
        tbl[5] = '{0, 0, 3, 3, 6, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 6, 2, 5, -1, 0, 10, 16};

        pat = 12'b101_010_111_000;
        for (int k = 0; k < 16; k++) fmem[k] = 1'b0;
        for (int k = 0; k < 12; k++) fmem[k] = pat[11 - k];

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        sprite_x = '0;
        sprite_y = '0;
        fg = '0;
        bg = '0;
        sc = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_frame(tbl[t].sx, tbl[t].sy, tbl[t].scol, tbl[t].f, tbl[t].b,
                      tbl[t].ab, tbl[t].glitch, p0, p1);
            chk($sformatf("vec%0d_plots0", t), p0, tbl[t].ep0);
            chk($sformatf("vec%0d_plots1", t), p1, tbl[t].ep1);
        end

        // reset mid-frame must clear outputs before any clock edge
        fg = 3'd3;
        bg = 3'd6;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            start = (c == 0);
            sprite_x = 8'd1;
            sprite_y = 8'd1;
        end
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy%0d", d), d ? busy1 : busy0, 0);
            chk($sformatf("rst_done%0d", d), d ? done1 : done0, 0);
            chk($sformatf("rst_plot%0d", d), d ? b1.plot : b0.plot, 0);
            chk($sformatf("rst_rd%0d", d), d ? b1.mem_rd : b0.mem_rd, 0);
            chk($sformatf("rst_addr%0d", d), d ? b1.mem_addr : b0.mem_addr, 0);
            chk($sformatf("rst_x%0d", d), d ? b1.x : b0.x, 0);
            chk($sformatf("rst_y%0d", d), d ? b1.y : b0.y, 0);
            chk($sformatf("rst_col%0d", d), d ? b1.colour : b0.colour, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        run_frame(1, 1, 5, 3, 6, -1, 0, p0, p1);
        chk("post_rst_plots0", p0, 10);
        chk("post_rst_plots1", p1, 16);

        for (int r = 0; r < 10; r++) begin
            int ab, gl;
            for (int k = 0; k < 12; k++) fmem[k] = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : -1;
            gl = (ab < 0) ? int'($urandom_range(0, 1)) : 0;
            run_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), ab, gl, p0, p1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/playfield_renderer.md
Name: playfield_renderer

Overview:
- Parametrised successor to the game's screen-update block. On a start pulse it scans a 1-bit-per-cell playfield through a synchronous memory read port, then overlays a rectangular sprite, emitting one pixel per cycle on an x/y/colour/plot interface that drives vga_adapter directly.
- Signals completion with a done pulse. Sits between the game datapath (field RAM, sprite position) and the VGA adapter; the control FSM owns start and abort.

Parameters:
- FIELD_W, 120, playfield columns.
- FIELD_H, 100, playfield rows.
- X_OFF, 20, screen x of field column 0.
- Y_OFF, 10, screen y of field row 0.
- SPRITE_W, 4, sprite width in cells.
- SPRITE_H, 6, sprite height in cells.
- XW, 8, width of x coordinates.
- YW, 8, width of y coordinates.
- COLOUR_W, 3, colour width.
- DRAW_BG, 1, 1 = plot background cells in bg_colour; 0 = background cells transparent (plot low).
- ADDR_W, clog2(FIELD_W*FIELD_H), memory address width.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  synchronous; return to IDLE without done
- sprite_x  in  XW  sprite left column in field coordinates; latched on accepted start
- sprite_y  in  YW  sprite top row in field coordinates; latched on accepted start
- fg_colour  in  COLOUR_W  colour for wall cells (bit = 1)
- bg_colour  in  COLOUR_W  colour for empty cells (bit = 0)
- sprite_colour  in  COLOUR_W  sprite colour; latched on accepted start
- mem_addr  out  ADDR_W  field read address = col*FIELD_H + row
- mem_rd  out  1  read strobe
- mem_data  in  1  cell bit, valid exactly one cycle after mem_rd
- x  out  XW  pixel x
- y  out  YW  pixel y
- colour  out  COLOUR_W  pixel colour
- plot  out  1  pixel write enable
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; x, y, colour, mem_addr = 0; plot, mem_rd, busy, done = 0; latches cleared. Takes effect immediately, including mid-frame.
- States: IDLE, FIELD, SPRITE, DONE.
- IDLE: start=1 at cycle 0 latches the sprite inputs and moves to FIELD; busy rises at cycle 1.
- FIELD scan order is column-major: col 0..FIELD_W-1 outer, row 0..FIELD_H-1 inner.
- FIELD timing: cell k is addressed (mem_rd=1) at cycle 1+k and plotted at cycle 2+k.
  - Output: x = X_OFF+col, y = Y_OFF+row (registered, aligned with data).
  - mem_data=1: colour = fg_colour, plot=1.
  - mem_data=0: colour = bg_colour, plot = DRAW_BG.
- The last field read occurs at cycle FIELD_W*FIELD_H; state enters SPRITE on the next cycle. The final field pixel's plot overlaps the first sprite cycle's internal index 0, so the pipeline drains in-stream with no bubble.
- SPRITE: pixel (i,j), column-major, is emitted at cycle FIELD_W*FIELD_H+2+i*SPRITE_H+j.
  - Output: x = X_OFF+sprite_x+i, y = Y_OFF+sprite_y+j, colour = sprite_colour.
  - mem_rd = 0 throughout.
- Clipping: if sprite_x+i >= FIELD_W or sprite_y+j >= FIELD_H, plot=0 that cycle. Cycle count is unchanged. Compare at XW+1 bits so no wrap occurs.
- DONE: one cycle after the last sprite pixel; done=1, busy=1, plot=0; then IDLE with busy=0.
  - Total start-to-done latency: FIELD_W*FIELD_H + SPRITE_W*SPRITE_H + 2 cycles.
- start while busy: ignored; latched sprite values do not change.
- start in the DONE cycle: ignored. The earliest restart is the first IDLE cycle.
- abort=1 in any non-IDLE state: next cycle is IDLE with plot, mem_rd, busy = 0 and no done.
- abort and start asserted together in IDLE: abort wins and start is ignored.
- Field inputs fg_colour and bg_colour are sampled live; a change takes effect on the next plotted pixel.

Decomposition:
- Shared package jj_render_pkg holds the state encoding constants (IDLE=0, FIELD=1, SPRITE=2, DONE=3) and the default geometry constants (120, 100, 20, 10, 4, 6).
- One natural sub-module: raster_counter (parametrised WIDTH/HEIGHT column-major col/row counter with enable, clear, and a last flag). Instantiated twice, for the field scan and the sprite scan.

Test Plan:
All scenarios use FIELD_W=4, FIELD_H=3, SPRITE 2x2, X_OFF=20, Y_OFF=10, a memory model with 1-cycle latency, and field bits 101_010_111_000 (col 0..3).
- Start with sprite (1,1), DRAW_BG=1 -> 12 field plots at cycles 2..13 with (x,y) = (20,10),(20,11),(20,12),(21,10)…; colours match the bits; 4 sprite plots at (21,11),(21,12),(22,11),(22,12); done at cycle 18, exactly once.
- DRAW_BG=0, same frame -> only 6 field plots (cells with bit 1); all cycle positions unchanged; done at cycle 18.
- Sprite (3,2) -> only sprite pixel (23,12) plotted; the other three sprite cycles have plot=0; done at cycle 18.
- Start pulsed again at cycles 5 and 17 with a different sprite_x -> both ignored; the sprite is drawn at the originally latched position.
- abort at cycle 7 -> cycle 8: plot=0, busy=0, no done; a fresh start at cycle 9 runs a full frame with done at cycle 27.
- reset asserted at cycle 6 -> all outputs 0 immediately, without waiting for a clock edge; after release, start at the next cycle yields a normal frame.
